// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin FIFO write arbiter with occupancy mirror and read gate
// Optional per-producer grant and stall counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH  = 8,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*DWIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]          gnt,
   input  logic                        cons_rd_en,
   input  logic                        fifo_full,
   input  logic                        fifo_empty,
   output logic                        wr_en,
   output logic [DWIDTH-1:0]           wdata,
   output logic                        rd_en,
   output logic [$clog2(DEPTH+1)-1:0]  occ,
   output logic                        arb_full
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*CNT_W-1:0]    grant_cnt,
   output logic [CNT_W-1:0]            stall_cnt
`endif
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);
   localparam logic [PTR_W:0]   NREQ_V  = (PTR_W + 1)'(NUM_REQ);

   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              wr_en_q, wr_en_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;

   logic               can_issue;
   logic               any_gnt;
   logic [NUM_REQ-1:0] gnt_c;
   logic [PTR_W:0]     sum;
   logic [PTR_W-1:0]   cand;

   // Gating on occ rather than fifo_full alone accounts for the write still in the output register.
   assign can_issue = (occ_q < DEPTH_V) & ~fifo_full & ~rst;
   assign rd_en     = cons_rd_en & ~fifo_empty & ~rst;
   assign gnt       = gnt_c;
   assign wr_en     = wr_en_q;
   assign wdata     = wdata_q;
   assign occ       = occ_q;
   assign arb_full  = (occ_q == DEPTH_V);

   always_comb begin
      gnt_c   = '0;
      any_gnt = 1'b0;
      sum     = '0;
      cand    = '0;
      if (can_issue) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (sum >= NREQ_V) begin
               sum = sum - NREQ_V;
            end
            cand = PTR_W'(sum);
            if (!any_gnt && req[cand]) begin
               any_gnt     = 1'b1;
               gnt_c[cand] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      wr_en_d = any_gnt;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i]) begin
            wdata_d = req_data[i*DWIDTH +: DWIDTH];
            ptr_d   = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
         end
      end
      occ_d = occ_q + OCC_W'(any_gnt) - OCC_W'(rd_en);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         occ_q   <= '0;
         wr_en_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         occ_q   <= occ_d;
         wr_en_q <= wr_en_d;
         wdata_q <= wdata_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*CNT_W-1:0] grant_cnt_q, grant_cnt_d;
   logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

   always_comb begin
      grant_cnt_d = grant_cnt_q;
      stall_cnt_d = stall_cnt_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_c[i] && (grant_cnt_q[i*CNT_W +: CNT_W] != '1)) begin
            grant_cnt_d[i*CNT_W +: CNT_W] = grant_cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
         end
      end
      if ((|req) && !any_gnt && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign grant_cnt = grant_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - randomized and directed bench for fifo_wr_arbiter against a queue-level model
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DWIDTH  = 8;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 16;
   localparam int OCC_W   = $clog2(DEPTH + 1);

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic [NUM_REQ-1:0]         req = '0;
   logic [NUM_REQ*DWIDTH-1:0]  req_data = '0;
   logic [NUM_REQ-1:0]         gnt;
   logic                       cons_rd_en = 1'b0;
   logic                       fifo_full = 1'b0;
   logic                       fifo_empty = 1'b1;
   logic                       wr_en;
   logic [DWIDTH-1:0]          wdata;
   logic                       rd_en;
   logic [OCC_W-1:0]           occ;
   logic                       arb_full;
`ifdef FIFO_ARB_STATS_EN
   logic [NUM_REQ*CNT_W-1:0]   grant_cnt;
   logic [CNT_W-1:0]           stall_cnt;
`endif

   fifo_wr_arbiter #(
      .NUM_REQ(NUM_REQ), .DWIDTH(DWIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
      .cons_rd_en(cons_rd_en), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en), .occ(occ), .arb_full(arb_full)
`ifdef FIFO_ARB_STATS_EN
      , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model: rotating priority start, integer occupancy, one-deep write register
   int               m_ptr = 0;
   int               m_occ = 0;
   bit               m_wr = 0;
   logic [DWIDTH-1:0] m_wd = '0;
   int               m_gcnt [NUM_REQ];
   int               m_stall = 0;

   // FIFO environment
   int               f_cnt = 0;
   logic [DWIDTH-1:0] wlog [$];
   bit               full_prev = 0;

   logic [NUM_REQ-1:0] pend = '0;
   logic [NUM_REQ-1:0] obs_gnt;
   logic               obs_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input bit r, input logic [NUM_REQ-1:0] rq, input bit crd, input bit rnd);
      logic [NUM_REQ-1:0] eg;
      int gi;
      int j;
      bit exp_rd;
      bit d_wr;
      bit d_rd;
      logic [DWIDTH-1:0] d_wd;
      @(negedge clk);
      rst = r;
      cons_rd_en = crd;
      if (r) pend = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!pend[i]) req_data[i*DWIDTH +: DWIDTH] = rnd ? DWIDTH'($urandom) : DWIDTH'(8'hA0 + i);
      end
      req = rq | pend;
      #1;
      eg = '0;
      gi = -1;
      if (!r && m_occ < DEPTH && !fifo_full) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            j = (m_ptr + k) % NUM_REQ;
            if (gi < 0 && req[j]) gi = j;
         end
      end
      if (gi >= 0) eg[gi] = 1'b1;
      exp_rd = crd && !fifo_empty && !r;

      chk("gnt", 32'(gnt), 32'(eg));
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      chk("rd_en", 32'(rd_en), 32'(exp_rd));
      chk("occ", 32'(occ), 32'(m_occ));
      chk("occ_max", 32'(occ <= DEPTH), 32'd1);
      chk("arb_full", 32'(arb_full), 32'(m_occ == DEPTH));
      chk("wr_en", 32'(wr_en), 32'(m_wr));
      if (m_wr) chk("wdata", 32'(wdata), 32'(m_wd));
      chk("wr_while_full", 32'(wr_en & (fifo_full | full_prev)), 32'd0);
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < NUM_REQ; i++) chk("grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(m_gcnt[i]));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
      obs_gnt = gnt;
      obs_rd  = rd_en;
      d_wr = wr_en;
      d_wd = wdata;
      d_rd = rd_en;
      full_prev = fifo_full;

      @(posedge clk);
      #1;
      if (r) begin
         m_ptr = 0; m_occ = 0; m_wr = 0; m_wd = '0; m_stall = 0;
         for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = 0;
         f_cnt = 0;
         full_prev = 0;
      end else begin
         m_wr = (gi >= 0);
         if (gi >= 0) begin
            m_wd = req_data[gi*DWIDTH +: DWIDTH];
            m_ptr = (gi + 1) % NUM_REQ;
            if (m_gcnt[gi] < (1 << CNT_W) - 1) m_gcnt[gi]++;
         end else if (req != 0 && m_stall < (1 << CNT_W) - 1) begin
            m_stall++;
         end
         m_occ = m_occ + (gi >= 0 ? 1 : 0) - (exp_rd ? 1 : 0);
         if (d_rd && f_cnt > 0) f_cnt--;
         if (d_wr) begin
            f_cnt++;
            wlog.push_back(d_wd);
         end
      end
      fifo_full  = (f_cnt >= DEPTH);
      fifo_empty = (f_cnt == 0);
      pend = r ? '0 : (req & ~eg);
   endtask

   initial begin
      for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = 0;

      // reset with all requests high
      for (int c = 0; c < 3; c++) begin
         cycle(1'b1, 4'hF, 1'b0, 1'b0);
         chk("rst_gnt", 32'(obs_gnt), 32'd0);
      end
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);

      // all producers, consumer reading every cycle: order 0,1,2,3,0
      wlog.delete();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 4'hF, 1'b1, 1'b0);
         chk("rr_order", 32'(obs_gnt), 32'(1 << (k % 4)));
      end
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) chk("fifo_order", 32'(wlog[k]), 32'(8'hA0 + k));
      for (int k = 0; k < 10; k++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
      chk("drain_occ", 32'(occ), 32'd0);

      // single requester fills the FIFO
      for (int k = 0; k < DEPTH; k++) begin
         cycle(1'b0, 4'h4, 1'b0, 1'b1);
         chk("fill_gnt", 32'(obs_gnt), 32'h4);
      end
      chk("full_occ", 32'(occ), 32'(DEPTH));
      chk("full_flag", 32'(arb_full), 32'd1);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, 4'h4, 1'b0, 1'b1);
         chk("full_no_gnt", 32'(obs_gnt), 32'd0);
      end

      // one read from full: exactly one more grant
      cycle(1'b0, 4'h4, 1'b1, 1'b1);
      chk("full_rd_no_gnt", 32'(obs_gnt), 32'd0);
      chk("occ_after_rd", 32'(occ), 32'(DEPTH - 1));
      cycle(1'b0, 4'h4, 1'b0, 1'b1);
      chk("refill_gnt", 32'(obs_gnt), 32'h4);
      chk("refill_occ", 32'(occ), 32'(DEPTH));
      cycle(1'b0, 4'h4, 1'b0, 1'b1);
      chk("refull_no_gnt", 32'(obs_gnt), 32'd0);

      // drain, then read gating on an empty FIFO and write-to-read latency
      for (int k = 0; k < DEPTH + 4; k++) cycle(1'b0, 4'h0, 1'b1, 1'b1);
      cycle(1'b0, 4'h0, 1'b1, 1'b1);
      chk("empty_rd_en", 32'(obs_rd), 32'd0);
      chk("empty_occ", 32'(occ), 32'd0);
      cycle(1'b0, 4'h1, 1'b1, 1'b1);
      chk("single_gnt", 32'(obs_gnt), 32'h1);
      cycle(1'b0, 4'h0, 1'b1, 1'b1);
      chk("lat_rd_t1", 32'(obs_rd), 32'd0);
      cycle(1'b0, 4'h0, 1'b1, 1'b1);
      chk("lat_rd_t2", 32'(obs_rd), 32'd1);
      chk("lat_occ", 32'(occ), 32'd0);

      // reset right after a grant cancels the pending write and pointer
      cycle(1'b0, 4'h2, 1'b0, 1'b1);
      chk("pre_rst_gnt", 32'(obs_gnt), 32'h2);
      cycle(1'b1, 4'h2, 1'b0, 1'b1);
      chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
      chk("mid_rst_occ", 32'(occ), 32'd0);
`ifdef FIFO_ARB_STATS_EN
      chk("mid_rst_gcnt", 32'(|grant_cnt), 32'd0);
      chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
`endif
      cycle(1'b0, 4'hF, 1'b0, 1'b1);
      chk("post_rst_gnt", 32'(obs_gnt), 32'h1);

      // randomized traffic
      for (int k = 0; k < 800; k++) begin
         cycle(($urandom_range(0, 99) == 0), NUM_REQ'($urandom), ($urandom_range(0, 2) == 0), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
